// File: rtl/sms_dot_bus_arbiter.sv
// Round-robin owner arbiter for a shared wired-OR card net: startup hold-off,
// guard dead-time between owners and an optional per-owner hold timeout.
module sms_dot_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GUARD_CYC   = 2,
    parameter int MAX_HOLD    = 16,
    parameter int STARTUP_CYC = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         rel,
    input  logic                     err_clr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     drv_en,
    output logic                     bus_busy,
    output logic                     timeout_err
);

    localparam int ID_W    = $clog2(N_REQ);
    localparam int CNT_MAX = (STARTUP_CYC > GUARD_CYC) ? STARTUP_CYC : GUARD_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int HOLD_W  = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_GRANT,
        ST_GUARD
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_nx;
    logic [ID_W-1:0]   rr_ptr, rr_nx;
    logic [N_REQ-1:0]  gnt_nx;
    logic [ID_W-1:0]   gnt_id_nx;
    logic              drv_nx;
    logic              busy_nx;
    logic              err_nx;
    logic              timeout_set;
    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic              own_rel;
    logic              own_req;
    logic              hold_hit;

    // Search starts just after the last owner, so that owner ranks lowest.
    // An X/Z request bit makes the if-condition false and is never picked.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [ID_W-1:0]  ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!res[ID_W] && r[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    assign own_rel  = rel[gnt_id];
    assign own_req  = req[gnt_id];
    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hold_nx     = hold_cnt;
        rr_nx       = rr_ptr;
        gnt_nx      = gnt;
        gnt_id_nx   = gnt_id;
        drv_nx      = drv_en;
        busy_nx     = bus_busy;
        timeout_set = 1'b0;
        {win_found, win_id} = rr_pick(req, rr_ptr);

        case (state)
            ST_STARTUP: begin
                if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_IDLE: begin
                if (win_found) begin
                    state_nx  = ST_GRANT;
                    gnt_nx    = N_REQ'(1) << win_id;
                    gnt_id_nx = win_id;
                    drv_nx    = 1'b1;
                    busy_nx   = 1'b1;
                    rr_nx     = win_id;
                    hold_nx   = HOLD_W'(1);
                end
            end
            ST_GRANT: begin
                if (own_rel || !own_req || hold_hit) begin
                    // A release that coincides with the limit is a clean release.
                    timeout_set = hold_hit && !own_rel && own_req;
                    gnt_nx      = '0;
                    drv_nx      = 1'b0;
                    if (GUARD_CYC > 0) begin
                        state_nx = ST_GUARD;
                        cnt_nx   = CNT_W'(GUARD_CYC);
                    end else begin
                        state_nx  = ST_IDLE;
                        busy_nx   = 1'b0;
                        gnt_id_nx = '0;
                    end
                end else if (MAX_HOLD != 0) begin
                    hold_nx = hold_cnt + 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nx  = ST_IDLE;
                    busy_nx   = 1'b0;
                    gnt_id_nx = '0;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = ST_STARTUP;
            end
        endcase

        if (timeout_set) begin
            err_nx = 1'b1;
        end else if (err_clr) begin
            err_nx = 1'b0;
        end else begin
            err_nx = timeout_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_STARTUP;
            cnt         <= CNT_W'(STARTUP_CYC);
            hold_cnt    <= '0;
            rr_ptr      <= ID_W'(N_REQ - 1);
            gnt         <= '0;
            gnt_id      <= '0;
            drv_en      <= 1'b0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            hold_cnt    <= hold_nx;
            rr_ptr      <= rr_nx;
            gnt         <= gnt_nx;
            gnt_id      <= gnt_id_nx;
            drv_en      <= drv_nx;
            bus_busy    <= busy_nx;
            timeout_err <= err_nx;
        end
    end

endmodule
